imem_stall_responder: RTL and testbench

Multi-cycle instruction-memory responder that serves the fetch stage's PC-addressed read requests with a fixed, parameterized latency. It sits on the far side of the fetch interface and asserts `stall` while a read is in flight. On completion it returns the 16-bit instruction with a one-cycle `done` strobe. It also lets fetch cancel an in-flight read on a redirect, and it provides a load port for bench/boot preloading of the storage array.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_array.sv | 26 ++
 rtl/imem_stall_responder.sv | 114 +++++++++++
 tb/tb_imem_stall_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory stall responder.
// Holds the FSM state encoding, the word width and the latency counter sizing helper.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] INSTR_ZERO = 16'h0000;

    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: 2^DEPTH_LOG2 x WORD_W words, synchronous write, combinational read.
// Contents survive reset so a preloaded image stays valid across resets.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [WORD_W-1:0]     rd_data
);

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_stall_responder.sv
// Fixed-latency instruction-memory responder: accepts a fetch read, stalls for LATENCY
// cycles, then presents the captured word with a one-cycle done strobe. Supports flush.
module imem_stall_responder
    import imem_pkg::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic [15:0]       addr,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [15:0]       wr_addr,
    input  logic [15:0]       wr_data,
    output logic [WORD_W-1:0] data_out,
    output logic              done,
    output logic              stall,
    output logic              err
);

    localparam int CNT_W = cnt_width(int'(LATENCY));
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam state_t ACCEPT_STATE = (LATENCY == 1) ? DONE : BUSY;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              accept;
    logic [WORD_W-1:0] array_word;
    logic [WORD_W-1:0] pend_data_p1;
    logic              pend_err_p1;
    logic              unused_bits;

    imem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_idx (wr_addr[DEPTH_LOG2:1]),
        .wr_data(wr_data),
        .rd_idx (addr[DEPTH_LOG2:1]),
        .rd_data(array_word)
    );

    // Upper address bits alias by design; the write-port LSB is meaningless for word writes.
    assign unused_bits = ^{addr, wr_addr};

    // Stall is decoded from state, so a new request is taken in IDLE or in the DONE cycle.
    assign accept = rd && !flush && (state_q != BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCEPT_STATE;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = ACCEPT_STATE;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // p0 -> p1: capture the addressed word and misalignment flag at acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_data_p1 <= array_word;
            pend_err_p1  <= addr[0];
        end
    end

    assign done     = (state_q == DONE);
    assign stall    = (state_q == BUSY);
    assign err      = done && pend_err_p1;
    assign data_out = (done && !pend_err_p1) ? pend_data_p1 : INSTR_ZERO;

endmodule

// File: tb/tb_imem_stall_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a time-based
// reference model that tracks the completion cycle of the single outstanding read.
module tb_imem_stall_responder;

    localparam int LAT = 4;
    localparam int DL  = 10;
    localparam int NW  = 1 << DL;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic [15:0] addr;
    logic        flush;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_m [NW];
    bit          pv;
    int          due;
    logic [15:0] pw;
    bit          pe;
    int          cyc;

    imem_stall_responder #(
        .LATENCY   (LAT),
        .DEPTH_LOG2(DL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd      (rd),
        .addr    (addr),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data_out(data_out),
        .done    (done),
        .stall   (stall),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [15:0] a);
        return (int'(a) >> 1) % NW;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        bit d_e;
        bit s_e;
        d_e = pv && (cyc == due);
        s_e = pv && (cyc < due);
        chk({tag, ".done"},  {15'b0, done},  {15'b0, d_e});
        chk({tag, ".stall"}, {15'b0, stall}, {15'b0, s_e});
        chk({tag, ".err"},   {15'b0, err},   {15'b0, d_e && pe});
        chk({tag, ".data"},  data_out,       (d_e && !pe) ? pw : 16'h0000);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check outputs.
    task automatic step(input bit r, input logic [15:0] a, input bit f,
                        input bit w, input logic [15:0] wa, input logic [15:0] wd,
                        input string tag);
        bit stall_now;
        bit done_now;
        bit acc;
        rd = r; addr = a; flush = f; wr_en = w; wr_addr = wa; wr_data = wd;
        stall_now = pv && (cyc < due);
        done_now  = pv && (cyc == due);
        if (stall_now && f) pv = 1'b0;
        if (done_now) pv = 1'b0;
        acc = r && !f && !stall_now;
        if (acc) begin
            pw  = mem_m[widx(a)];
            pe  = a[0];
            due = cyc + LAT;
            pv  = 1'b1;
        end
        if (w) mem_m[widx(wa)] = wd;
        @(posedge clk);
        #1;
        cyc++;
        chk_outputs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, tag);
    endtask

    task automatic do_reset(input string tag);
        rd = 1'b0; flush = 1'b0; wr_en = 1'b0;
        rst = 1'b1;
        #1;
        pv = 1'b0;
        chk_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; addr = '0; flush = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pv = 1'b0; due = 0; pw = '0; pe = 1'b0; cyc = 0;
        #2;
        chk_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NW; i++)
            step(1'b0, 16'h0, 1'b0, 1'b1, 16'(i * 2), 16'($urandom), "preload");
        step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'hA55A, "preload_a55a");
        step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'h0BAD, "preload_10");

        do_reset("reset2");

        step(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, "basic_req");
        idle(LAT + 1, "basic");

        for (int i = 0; i < LAT; i++)
            step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, "b2b_first");
        step(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0, "b2b_second");
        idle(LAT + 1, "b2b");

        step(1'b1, 16'h0041, 1'b0, 1'b0, 16'h0, 16'h0, "misaligned_req");
        idle(LAT + 1, "misaligned");

        step(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, "flush_req");
        idle(1, "flush_busy");
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0, "flush");
        idle(LAT + 1, "flush_after");
        step(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0, 16'h0, "rd_flush_same");
        idle(2, "rd_flush_idle");
        step(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0, "post_flush_req");
        idle(LAT + 1, "post_flush");

        step(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0010, 16'h1234, "hazard_req");
        idle(LAT + 1, "hazard");
        step(1'b1, 16'h0810, 1'b0, 1'b0, 16'h0, 16'h0, "wrap_req");
        idle(LAT + 1, "wrap");

        step(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, "rstmid_req");
        idle(1, "rstmid_busy");
        do_reset("rstmid_reset");
        step(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, "rstmid_reread");
        idle(LAT + 1, "rstmid_after");

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 4) == 0), 16'($urandom), 16'($urandom), "random");
        idle(LAT + 1, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
